mont_operand_multiplier: RTL
============================

Name: mont_operand_multiplier

Overview:
- Sequential radix-2 shift-add multiplier. It sits directly upstream of montgomery_parallel.
- Takes two Dilithium-domain operands over a valid/ready handshake and produces the full product. That product is the x_i input of the combinational Montgomery reduction.
- Fixed, data-independent latency. Holds its result under downstream backpressure.

Parameters:
- OPERAND_WIDTH, 32, width of each input operand.
- DATA_LENGTH, 64, width of product_o. Must equal the reduction's DATA_LENGTH and satisfy DATA_LENGTH >= 2*OPERAND_WIDTH; a static elaboration check enforces this.
- CNT_WIDTH, $clog2(OPERAND_WIDTH+1), width of the iteration counter.

Ports:
- clk_i  in  1  clock; rising edge active.
- rst_i  in  1  synchronous reset, active-high.
- in_valid_i  in  1  operands a_i/b_i are valid.
- in_ready_o  out  1  block can accept operands this cycle.
- a_i  in  OPERAND_WIDTH  multiplicand.
- b_i  in  OPERAND_WIDTH  multiplier.
- out_valid_o  out  1  product_o holds a finished product.
- out_ready_i  in  1  downstream consumes product this cycle.
- product_o  out  DATA_LENGTH  a*b, zero-extended.
- busy_o  out  1  a multiplication is in progress.

Behaviour:
- States: IDLE, MUL, DONE. Registers:
  - a_sh (DATA_LENGTH): shifted multiplicand.
  - b_sh (OPERAND_WIDTH): shifted multiplier.
  - acc (DATA_LENGTH): accumulator.
  - cnt (CNT_WIDTH): iteration counter.
- Reset (rst_i high at a clock edge): state=IDLE; acc, a_sh, b_sh, cnt cleared.
  - While rst_i is high: in_ready_o=0, out_valid_o=0, busy_o=0, product_o=0.
  - Reset mid-MUL or mid-DONE aborts the operation; the in-flight result is discarded and never presented.
- in_ready_o = !rst_i && (state==IDLE || (state==DONE && out_ready_i)).
- Accept = in_valid_i && in_ready_o. On the accept edge:
  - a_sh <= zero-extended a_i; b_sh <= b_i; acc <= 0; cnt <= 0; state <= MUL.
- MUL, each edge:
  - if b_sh[0], acc <= acc + a_sh;
  - a_sh <= a_sh << 1; b_sh <= b_sh >> 1; cnt <= cnt + 1.
  - When cnt == OPERAND_WIDTH-1, state <= DONE.
  - Exactly OPERAND_WIDTH MUL cycles, no early exit, even if b_sh becomes 0.
- Latency: accept at edge N gives out_valid_o=1 after edge N+OPERAND_WIDTH (32 cycles at the default).
- Arithmetic: unsigned. acc never overflows because 2*OPERAND_WIDTH <= DATA_LENGTH. In_valid_i is ignored while in MUL.
- DONE:
  - out_valid_o=1; product_o=acc, held stable until the handshake.
  - out_valid_o stays high without out_ready_i; in_ready_o stays low.
- Leaving DONE, on an edge with out_ready_i=1:
  - if in_valid_i is also 1 (back-to-back), the new operands are accepted on that same edge and state goes to MUL;
  - otherwise state goes to IDLE.
- busy_o = (state==MUL).
- product_o is 0 in IDLE and MUL (acc is not exposed mid-computation). It is registered-derived; no combinational path from inputs.
- out_valid_o and in_ready_o depend only on state, rst_i and out_ready_i. There is no combinational path from in_valid_i to in_ready_o.

Test Plan:
- Reset, then in_valid=1 with a=3, b=5 and out_ready=1 -> in_ready_o=1 at accept; busy_o=1 for exactly 32 cycles; out_valid_o=1 at cycle 32 with product_o=0x000000000000000F; in_ready_o returns high the next cycle.
- a=0xFFFFFFFF, b=0xFFFFFFFF -> product_o=0xFFFFFFFE00000001 after 32 cycles. a=0, b=0xFFFFFFFF -> product_o=0, still 32 cycles of latency.
- a=b=8380416 (q-1) -> product_o=0x00003FE004000000. Feeding it to montgomery_parallel gives the result checked against 0x3FE004000000 mod 8380417.
- a=7, b=9 with out_ready_i=0 for 10 cycles after out_valid_o rises -> product_o stays 0x3F and out_valid_o stays 1 while in_ready_o=0. Then out_ready_i=1 for one cycle -> next state IDLE.
- Back-to-back: in DONE holding 0x3F, out_ready_i=1 and in_valid_i=1 with a=2, b=4 in the same cycle -> 0x3F consumed, new operands accepted, product_o=0x8 after 32 more cycles.
- Reset mid-MUL: accept a=3, b=5, assert rst_i at MUL cycle 10 -> the next cycle out_valid_o=0, busy_o=0, product_o=0; the 15 never appears. A new request a=1, b=1 after reset returns 0x1.

Source files
------------

// File: rtl/mont_operand_multiplier_if.sv
// Operand/product handshake bundle for mont_operand_multiplier.
// The slave side is the multiplier. The master side is whoever feeds
// operands in and consumes products.
interface mont_operand_multiplier_if #(
  parameter int OPERAND_WIDTH = 32,
  parameter int DATA_LENGTH   = 64
);
  logic                     in_valid_i;
  logic                     in_ready_o;
  logic [OPERAND_WIDTH-1:0] a_i;
  logic [OPERAND_WIDTH-1:0] b_i;
  logic                     out_valid_o;
  logic                     out_ready_i;
  logic [DATA_LENGTH-1:0]   product_o;
  logic                     busy_o;

  modport slave (
    input  in_valid_i, a_i, b_i, out_ready_i,
    output in_ready_o, out_valid_o, product_o, busy_o
  );

  modport master (
    output in_valid_i, a_i, b_i, out_ready_i,
    input  in_ready_o, out_valid_o, product_o, busy_o
  );
endinterface

// File: rtl/mont_operand_multiplier.sv
// Sequential radix-2 shift-add multiplier feeding the Montgomery reduction.
// Every product takes exactly OPERAND_WIDTH cycles, whatever the operand values.
// A finished product is held in DONE until downstream takes it. A new pair of
// operands can be accepted on the same edge that the old product leaves.
module mont_operand_multiplier #(
  parameter int OPERAND_WIDTH = 32,
  parameter int DATA_LENGTH   = 64,
  parameter int CNT_WIDTH     = $clog2(OPERAND_WIDTH + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  mont_operand_multiplier_if.slave  bus
);

  // The full product must fit in the accumulator. This also keeps acc from
  // overflowing during accumulation.
  generate
    if (DATA_LENGTH < 2 * OPERAND_WIDTH) begin : g_width_check
      $error("mont_operand_multiplier: DATA_LENGTH must be >= 2*OPERAND_WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(OPERAND_WIDTH - 1);

  state_t                   state;
  logic [DATA_LENGTH-1:0]   a_sh;
  logic [OPERAND_WIDTH-1:0] b_sh;
  logic [DATA_LENGTH-1:0]   acc;
  logic [CNT_WIDTH-1:0]     cnt;

  logic in_ready;
  logic accept;

  // Ready depends only on state, reset and downstream ready. It never looks at
  // in_valid, so no combinational loop can form through the handshake.
  assign in_ready = !rst_i && ((state == IDLE) || ((state == DONE) && bus.out_ready_i));
  assign accept   = bus.in_valid_i && in_ready;

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = !rst_i && (state == DONE);
  assign bus.busy_o      = !rst_i && (state == MUL);
  assign bus.product_o   = (!rst_i && (state == DONE)) ? acc : '0;

  // Control and datapath together: load on accept, then shift-add for
  // OPERAND_WIDTH cycles, then hold the result until downstream handshakes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      acc   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_sh  <= DATA_LENGTH'(bus.a_i);
            b_sh  <= bus.b_i;
            acc   <= '0;
            cnt   <= '0;
            state <= MUL;
          end
        end
        MUL: begin
          if (b_sh[0]) begin
            acc <= acc + a_sh;
          end
          a_sh <= a_sh << 1;
          b_sh <= b_sh >> 1;
          cnt  <= cnt + CNT_WIDTH'(1);
          if (cnt == LAST_CNT) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (accept) begin
            a_sh  <= DATA_LENGTH'(bus.a_i);
            b_sh  <= bus.b_i;
            acc   <= '0;
            cnt   <= '0;
            state <= MUL;
          end else if (bus.out_ready_i) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
